aes_key_expander: RTL and testbench
===================================

// Module: aes_key_expander
// PURPOSE
//  Iterative AES key schedule (FIPS-197 §5.2) feeding the cipher's flat ExpandedKeys bus.
//  Loads a cipher key on start, then derives one 32-bit schedule word per clock.
//  Holds the full 128*(NR+1)-bit result stable, with ready high, until the next start or reset.
// PARAMETERS
//  NK  4   key length in 32-bit words (4/6/8 = AES-128/192/256)
//  NR  10  number of rounds (10/12/14, must match NK)
// PORTS
//  clk            in   1             rising-edge clock
//  reset          in   1             asynchronous, active-high
//  start          in   1             load key_in and begin expansion (accepted only when not busy)
//  key_in         in   32*NK         cipher key, word 0 in MSBs
//  busy           out  1             expansion in progress
//  ready          out  1             expanded_keys complete and valid
//  expanded_keys  out  128*(NR+1)    w[0] at MSBs; round-0 key = top 128 bits, round-NR key = [127:0]
// BEHAVIOUR
//  Reset (async): state IDLE; busy=0, ready=0, expanded_keys=0, word index=0, rcon index=0.
//  FSM: IDLE -> EXPAND on start; EXPAND -> DONE after word 4*(NR+1)-1 is written;
//    DONE -> EXPAND on start; DONE otherwise holds.
//  Start edge: w[0..NK-1] <= key_in; all other words <= 0; i <= NK; ready <= 0; busy <= 1.
//  EXPAND: each edge writes w[i] = w[i-NK] ^ temp, then i <= i+1.
//    temp = SubWord(RotWord(w[i-1])) ^ {Rcon[i/NK],24'h0} when i%NK==0.
//    temp = SubWord(w[i-1]) when NK>6 && i%NK==4.
//    temp = w[i-1] otherwise.
//  Rcon: 01,02,04,08,10,20,40,80,1b,36, i.e. GF(2^8) doubling; counter advances on every i%NK==0 step.
//  Latency: ready rises on the edge writing the last word, 4*(NR+1)-NK cycles after the start edge
//    (40 / 46 / 52 for AES-128/192/256). busy falls on the same edge.
//  start while busy: ignored; expansion continues undisturbed.
//  start while ready: restart; ready drops the next edge and expanded_keys are cleared/reloaded.
//  key_in sampled only on the accepted start edge; later changes have no effect.
//  reset mid-expansion: immediate return to reset values; partial words discarded.
//  Partial expanded_keys are visible while busy; consumers qualify with ready only.
// CONFIGURATION
//  AES_KEYEXP_STREAM_EN defined: adds outputs rk_valid (1), rk_index (4), rk_data (128).
//    rk_valid pulses 1 cycle after each edge that completes a round key's 4th word.
//    rk_index is the round number 0..NR.
//    Round keys covered by the loaded key (rounds < NK/4) pulse on consecutive cycles after the start edge.
//    All stream outputs reset to 0.
//  Not defined: stream ports are absent; behaviour is otherwise identical.
// STRUCTURE
//  Shared package aes_pkg:
//    FSM state typedef (IDLE/EXPAND/DONE)
//    Rcon constant table
//    S-box constant table / function
//    localparam TOTAL_WORDS = 4*(NR+1)
//  Sub-module aes_sub_word: combinational 32-bit SubWord built from four S-box lookups, one instance.
//  Index counter width = $clog2(4*(NR+1)+1).
// TESTING
//  1. NK=4, FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c:
//     w[4]=a0fafe17; ready after 40 cycles; expanded_keys[127:0]=d014f9a8c9ee2589e13f0cc8b6630ca6.
//  2. NK=8, NR=14, A.3 key 603deb10...0914dff4:
//     ready after 52 cycles; last round key fe4890d1e6188d0b046df344706c631e.
//  3. start pulsed again at cycle 10 of an expansion, with a different key_in -> ignored; result identical to test 1.
//  4. Assert reset at cycle 20 -> busy=ready=0, expanded_keys=0 immediately;
//     a new start then completes normally.
//  5. After ready, start with the all-zero key -> ready low next edge;
//     ready again after 40 cycles; last round key b4ef5bcb3e92e21123e951cf6f8f188e.
//  6. AES_KEYEXP_STREAM_EN, test 1 key -> 11 rk_valid pulses, rk_index 0..10, each rk_data equal to its expanded_keys slice.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: FSM state type, Rcon and S-box tables, schedule size.
package aes_pkg;

  localparam int unsigned NR_DEFAULT  = 10;
  localparam int unsigned TOTAL_WORDS = 4 * (NR_DEFAULT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DONE
  } kx_state_e;

  // Rcon[1..10]; entry 0 here is the first round constant (01)
  localparam logic [79:0] RCON_TABLE = 80'h01020408102040801b36;

  // Forward S-box, entry 0 in the MSBs
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0:    r = RCON_TABLE[79:72];
      4'd1:    r = RCON_TABLE[71:64];
      4'd2:    r = RCON_TABLE[63:56];
      4'd3:    r = RCON_TABLE[55:48];
      4'd4:    r = RCON_TABLE[47:40];
      4'd5:    r = RCON_TABLE[39:32];
      4'd6:    r = RCON_TABLE[31:24];
      4'd7:    r = RCON_TABLE[23:16];
      4'd8:    r = RCON_TABLE[15:8];
      4'd9:    r = RCON_TABLE[7:0];
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Key-expander bus: start/key_in toward the expander, schedule and status back.
// AES_KEYEXP_STREAM_EN adds the per-round-key stream signals.
interface aes_key_expander_if #(
  parameter int unsigned NK = 4,
  parameter int unsigned NR = 10
) ();

  logic                    start;
  logic [32*NK-1:0]        key_in;
  logic                    busy;
  logic                    ready;
  logic [128*(NR+1)-1:0]   expanded_keys;
`ifdef AES_KEYEXP_STREAM_EN
  logic                    rk_valid;
  logic [3:0]              rk_index;
  logic [127:0]            rk_data;

  modport master (output start, key_in,
                  input  busy, ready, expanded_keys, rk_valid, rk_index, rk_data);
  modport slave  (input  start, key_in,
                  output busy, ready, expanded_keys, rk_valid, rk_index, rk_data);
`else
  modport master (output start, key_in, input  busy, ready, expanded_keys);
  modport slave  (input  start, key_in, output busy, ready, expanded_keys);
`endif

endinterface

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub_word_c
);

  always_comb begin
    sub_word_c = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};
  end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES key schedule, one 32-bit word per clock into a flat round-key bus.
// AES_KEYEXP_STREAM_EN adds a rk_valid/rk_index/rk_data round-key stream.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int unsigned NK = 4,
  parameter int unsigned NR = 10
) (
  input  logic             clk,
  input  logic             reset,
  aes_key_expander_if.slave bus
);

  localparam int unsigned NUM_WORDS = 4 * (NR + 1);
  localparam int unsigned IDX_W     = $clog2(NUM_WORDS + 1);
  localparam int unsigned MOD_W     = $clog2(NK);
  localparam int unsigned RCON_W    = 4;

  kx_state_e           state_q, state_d;
  logic                busy_q, ready_q;
  logic [IDX_W-1:0]    idx_q;
  logic [MOD_W-1:0]    mod_q;
  logic [RCON_W-1:0]   rcon_idx_q;
  logic [31:0]         w_q [NUM_WORDS];

  logic                load_c, step_c, rot_step_c, sub_step_c;
  logic [31:0]         prev_c, back_c, sub_in_c, sub_out_c, temp_c;
  logic [128*(NR+1)-1:0] expanded_c;

  // State register; status flags follow the next state so they change on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_EXPAND);
      ready_q <= (state_d == ST_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_EXPAND;
      ST_EXPAND: if (idx_q == IDX_W'(NUM_WORDS - 1)) state_d = ST_DONE;
      ST_DONE:   if (bus.start) state_d = ST_EXPAND;
      default:   state_d = ST_IDLE;
    endcase
  end

  // start is only honoured outside an expansion
  always_comb begin
    load_c = 1'b0;
    step_c = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: load_c = bus.start;
      ST_EXPAND:        step_c = 1'b1;
      default:          ;
    endcase
  end

  always_comb begin
    prev_c     = w_q[idx_q - IDX_W'(1)];
    back_c     = w_q[idx_q - IDX_W'(NK)];
    rot_step_c = (mod_q == '0);
    sub_step_c = (NK > 6) && (mod_q == MOD_W'(4));
    sub_in_c   = rot_step_c ? {prev_c[23:0], prev_c[31:24]} : prev_c;
    if (rot_step_c)      temp_c = sub_out_c ^ {rcon(rcon_idx_q), 24'h000000};
    else if (sub_step_c) temp_c = sub_out_c;
    else                 temp_c = prev_c;
  end

  aes_sub_word u_sub_word (
    .word       (sub_in_c),
    .sub_word_c (sub_out_c)
  );

  // Schedule storage, word index, i%NK tracker and Rcon counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < NUM_WORDS; j++) w_q[j] <= '0;
      idx_q      <= '0;
      mod_q      <= '0;
      rcon_idx_q <= '0;
    end else if (load_c) begin
      for (int j = 0; j < NUM_WORDS; j++) w_q[j] <= '0;
      for (int j = 0; j < NK; j++) w_q[j] <= bus.key_in[32*(NK-j)-1 -: 32];
      idx_q      <= IDX_W'(NK);
      mod_q      <= '0;
      rcon_idx_q <= '0;
    end else if (step_c) begin
      w_q[idx_q] <= back_c ^ temp_c;
      idx_q      <= idx_q + IDX_W'(1);
      mod_q      <= (mod_q == MOD_W'(NK - 1)) ? '0 : mod_q + MOD_W'(1);
      if (rot_step_c) rcon_idx_q <= rcon_idx_q + RCON_W'(1);
    end
  end

  always_comb begin
    expanded_c = '0;
    for (int j = 0; j < NUM_WORDS; j++) expanded_c[32*(NUM_WORDS-j)-1 -: 32] = w_q[j];
  end

  assign bus.expanded_keys = expanded_c;
  assign bus.busy          = busy_q;
  assign bus.ready         = ready_q;

`ifdef AES_KEYEXP_STREAM_EN
  logic [3:0]       rk_next_q, rk_index_q;
  logic             rk_valid_q;
  logic [127:0]     rk_data_q;
  logic [IDX_W-1:0] rk_base_c;
  logic             rk_emit_c;

  // A round key is emitted once all four of its words have been written (idx past its last word)
  always_comb begin
    rk_base_c = IDX_W'({rk_next_q, 2'b00});
    rk_emit_c = (rk_next_q <= 4'(NR)) && (idx_q > rk_base_c + IDX_W'(3));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rk_next_q  <= '0;
      rk_valid_q <= 1'b0;
      rk_index_q <= '0;
      rk_data_q  <= '0;
    end else if (load_c) begin
      rk_next_q  <= '0;
      rk_valid_q <= 1'b0;
    end else begin
      rk_valid_q <= rk_emit_c;
      if (rk_emit_c) begin
        rk_index_q <= rk_next_q;
        rk_data_q  <= {w_q[rk_base_c], w_q[rk_base_c + IDX_W'(1)],
                       w_q[rk_base_c + IDX_W'(2)], w_q[rk_base_c + IDX_W'(3)]};
        rk_next_q  <= rk_next_q + 4'd1;
      end
    end
  end

  assign bus.rk_valid = rk_valid_q;
  assign bus.rk_index = rk_index_q;
  assign bus.rk_data  = rk_data_q;
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander: AES-128 and AES-256 instances against FIPS-197 vectors.
module tb_aes_key_expander;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_key_expander_if #(.NK(4), .NR(10)) bus128 ();
  aes_key_expander_if #(.NK(8), .NR(14)) bus256 ();

  aes_key_expander #(.NK(4), .NR(10)) u_dut128 (.clk(clk), .reset(reset), .bus(bus128));
  aes_key_expander #(.NK(8), .NR(14)) u_dut256 (.clk(clk), .reset(reset), .bus(bus256));

  localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] KEY_A3   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] A1_RK [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  typedef struct {
    int unsigned  latency;
    logic [127:0] rk0;
    logic [127:0] rk1;
    logic [127:0] last_rk;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start128(input logic [127:0] key, input exp_t e);
    @(negedge clk);
    bus128.key_in = key;
    bus128.start  = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    bus128.start  = 1'b0;
  endtask

  // Waits for ready; optionally pulses start with alt_key at cycle disturb_at
  task automatic wait128(input int unsigned disturb_at, input logic [127:0] alt_key,
                         output int unsigned cyc);
    cyc = 0;
    while (!bus128.ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == disturb_at) begin
        bus128.start  = 1'b1;
        bus128.key_in = alt_key;
      end else begin
        bus128.start  = 1'b0;
      end
    end
    bus128.start = 1'b0;
  endtask

  task automatic score128(input string tag, input int unsigned cyc);
    exp_t             e;
    logic [1407:0]    ek;
    check({tag, "_sb_depth"}, 128'(exp_q.size()), 128'd1);
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      ek = bus128.expanded_keys;
      check({tag, "_latency"}, 128'(cyc), 128'(e.latency));
      check({tag, "_busy"}, 128'(bus128.busy), 128'd0);
      check({tag, "_rk0"}, 128'(ek >> 1280), e.rk0);
      check({tag, "_rk1"}, 128'(ek >> 1152), e.rk1);
      check({tag, "_last"}, 128'(ek), e.last_rk);
    end
  endtask

`ifdef AES_KEYEXP_STREAM_EN
  logic [3:0]   rk_idx_q[$];
  logic [127:0] rk_dat_q[$];
  always @(negedge clk) begin
    if (bus128.rk_valid) begin
      rk_idx_q.push_back(bus128.rk_index);
      rk_dat_q.push_back(bus128.rk_data);
    end
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t          e;
    int unsigned   cyc;
    logic [1407:0] ek;
    logic [1919:0] ek256;

    reset         = 1'b1;
    bus128.start  = 1'b0;
    bus128.key_in = '0;
    bus256.start  = 1'b0;
    bus256.key_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(bus128.busy), 128'd0);
    check("rst_ready", 128'(bus128.ready), 128'd0);
    check("rst_keys", 128'(bus128.expanded_keys | (bus128.expanded_keys >> 128)), 128'd0);
    check("rst_ready256", 128'(bus256.ready), 128'd0);
    reset = 1'b0;
    @(negedge clk);

    // Test 1: FIPS A.1, every round key checked
`ifdef AES_KEYEXP_STREAM_EN
    rk_idx_q.delete();
    rk_dat_q.delete();
`endif
    e = '{latency: 40, rk0: A1_RK[0], rk1: A1_RK[1], last_rk: A1_RK[10]};
    start128(KEY_A1, e);
    check("t1_busy_after_start", 128'(bus128.busy), 128'd1);
    wait128(0, '0, cyc);
    score128("t1", cyc);
    ek = bus128.expanded_keys;
    check("t1_w4", 128'(ek >> 1248) & 128'hffffffff, 128'ha0fafe17);
    for (int r = 0; r < 11; r++)
      check($sformatf("t1_round%0d", r), 128'(ek >> (128 * (10 - r))), A1_RK[r]);

`ifdef AES_KEYEXP_STREAM_EN
    // Test 6: round-key stream
    repeat (4) @(negedge clk);
    check("t6_count", 128'(rk_idx_q.size()), 128'd11);
    for (int i = 0; i < rk_idx_q.size() && i < 11; i++) begin
      check($sformatf("t6_index%0d", i), 128'(rk_idx_q[i]), 128'(i));
      check($sformatf("t6_data%0d", i), rk_dat_q[i], A1_RK[i]);
    end
`endif

    // Test 3: restart from DONE, then an ignored start at cycle 10 with another key
    start128(KEY_A1, e);
    wait128(10, 128'h0, cyc);
    score128("t3", cyc);

    // Test 4: reset in the middle of an expansion
    start128(KEY_A1, e);
    repeat (20) @(negedge clk);
    check("t4_busy_mid", 128'(bus128.busy), 128'd1);
    reset = 1'b1;
    #1;
    check("t4_busy_rst", 128'(bus128.busy), 128'd0);
    check("t4_ready_rst", 128'(bus128.ready), 128'd0);
    check("t4_keys_hi_rst", 128'(bus128.expanded_keys >> 1280), 128'd0);
    check("t4_keys_w4_rst", 128'(bus128.expanded_keys >> 1152), 128'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    start128(KEY_A1, e);
    wait128(0, '0, cyc);
    score128("t4", cyc);

    // Test 5: all-zero key restart while ready
    e = '{latency: 40, rk0: 128'h0, rk1: 128'h62636363626363636263636362636363,
          last_rk: 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    start128(128'h0, e);
    check("t5_ready_drop", 128'(bus128.ready), 128'd0);
    check("t5_busy", 128'(bus128.busy), 128'd1);
    wait128(0, '0, cyc);
    score128("t5", cyc);

    // Test 2: AES-256, FIPS A.3
    e = '{latency: 52, rk0: KEY_A3[255:128], rk1: KEY_A3[127:0],
          last_rk: 128'hfe4890d1e6188d0b046df344706c631e};
    @(negedge clk);
    bus256.key_in = KEY_A3;
    bus256.start  = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    bus256.start  = 1'b0;
    cyc = 0;
    while (!bus256.ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("t2_sb_depth", 128'(exp_q.size()), 128'd1);
    if (exp_q.size() != 0) begin
      e     = exp_q.pop_front();
      ek256 = bus256.expanded_keys;
      check("t2_latency", 128'(cyc), 128'(e.latency));
      check("t2_busy", 128'(bus256.busy), 128'd0);
      check("t2_rk0", 128'(ek256 >> 1792), e.rk0);
      check("t2_rk1", 128'(ek256 >> 1664), e.rk1);
      check("t2_last", 128'(ek256), e.last_rk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
